// File: rtl/feram_sra_bank_ctrl_if.sv
// feram_sra_bank_ctrl_if: request/response bundle for the FeRAM row-access bank controller.
interface feram_sra_bank_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int LANES  = 4
);
    localparam int RW = LANES * DATA_W;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_row;
    logic [RW-1:0]     req_wdata;
    logic [LANES-1:0]  req_wmask;
    logic              rsp_valid;
    logic [RW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              rsp_hit;
    modport master (
        output req_valid, req_we, req_row, req_wdata, req_wmask,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_hit
    );
    modport slave (
        input  req_valid, req_we, req_row, req_wdata, req_wmask,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_hit
    );
endinterface

// File: rtl/feram_sra_bank_ctrl.sv
// feram_sra_bank_ctrl: FeRAM row array with open-row buffer and destructive sense + restore.
module feram_sra_bank_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int LANES       = 4,
    parameter int N_ROWS      = 16,
    parameter int RESTORE_CYC = 2
) (
    input logic                  clk,
    input logic                  rst,
    feram_sra_bank_ctrl_if.slave bus
);
    localparam int RW = LANES * DATA_W;
    localparam int CW = $clog2(RESTORE_CYC + 1);
    typedef enum logic [1:0] {IDLE, SENSE, RESTORE, WRITE} state_t;
    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_row;
    logic [RW-1:0]     r_wdata;
    logic [LANES-1:0]  r_wmask;
    logic [RW-1:0]     r_mem [N_ROWS];
    logic [RW-1:0]     r_buf;
    logic [ADDR_W-1:0] r_tag;
    logic              r_bvalid;
    logic              r_rsp_valid, r_rsp_err, r_rsp_hit;
    logic [RW-1:0]     r_rsp_rdata;
    logic              w_accept, w_oor, w_hit, w_last, w_wr_done;
    logic [RW-1:0]     w_mem_new, w_buf_new;
    assign w_last = r_cnt == CW'(RESTORE_CYC - 1);
    always_comb begin
        w_next = r_state;
        w_wr_done = 1'b0;
        bus.req_ready = r_state == IDLE;
        w_accept = bus.req_valid && bus.req_ready;
        w_oor = 32'(bus.req_row) >= N_ROWS;
        w_hit = r_bvalid && r_tag == bus.req_row;
        unique case (r_state)
            IDLE:    if (w_accept && !w_oor && (bus.req_we || !w_hit)) w_next = bus.req_we ? WRITE : SENSE;
            SENSE:   w_next = RESTORE;
            RESTORE: w_next = w_last ? IDLE : RESTORE;
            WRITE: begin
                w_next = w_last ? IDLE : WRITE;
                w_wr_done = w_last && !rst;
            end
            default: w_next = IDLE;
        endcase
    end
    // Writes respond combinationally on the cycle the array is updated.
    assign bus.rsp_valid = r_rsp_valid | w_wr_done;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_hit   = r_rsp_hit;
    always_comb begin
        w_mem_new = r_mem[r_row];
        w_buf_new = r_buf;
        for (int i = 0; i < LANES; i++)
            if (r_wmask[i]) begin
                w_mem_new[i*DATA_W +: DATA_W] = r_wdata[i*DATA_W +: DATA_W];
                w_buf_new[i*DATA_W +: DATA_W] = r_wdata[i*DATA_W +: DATA_W];
            end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state inside {RESTORE, WRITE} && !w_last) ? r_cnt + 1'b1 : '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bvalid    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_rdata <= '0;
            if (w_accept) begin
                r_row   <= bus.req_row;
                r_wdata <= bus.req_wdata;
                r_wmask <= bus.req_wmask;
                if (w_oor) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                end else if (!bus.req_we && w_hit) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_hit   <= 1'b1;
                    r_rsp_rdata <= r_buf;
                end
            end
            if (r_state == SENSE) begin
                r_buf       <= r_mem[r_row];
                r_tag       <= r_row;
                r_bvalid    <= 1'b1;
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= r_mem[r_row];
            end
            if (w_wr_done && r_bvalid && r_tag == r_row) r_buf <= w_buf_new;
        end
    end
    // Sensing clears the row even under reset, so an aborted restore loses the data.
    always_ff @(posedge clk) begin
        if (r_state == SENSE) r_mem[r_row] <= '0;
        else if (!rst && r_state == RESTORE && w_last) r_mem[r_row] <= r_buf;
        else if (w_wr_done) r_mem[r_row] <= w_mem_new;
    end
endmodule

// File: tb/tb_feram_sra_bank_ctrl.sv
// tb_feram_sra_bank_ctrl: directed requests with a scoreboard queue checked by a response monitor.
module tb_feram_sra_bank_ctrl;
    localparam int RC = 2;
    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        logic        hit;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    feram_sra_bank_ctrl_if #(.ADDR_W(4), .DATA_W(8), .LANES(4)) bus ();
    feram_sra_bank_ctrl #(
        .ADDR_W(4), .DATA_W(8), .LANES(4), .N_ROWS(12), .RESTORE_CYC(RC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp at cyc %0d rdata=%h", cyc, bus.rsp_rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.cyc || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err || bus.rsp_hit !== e.hit) begin
                    failures++;
                    $display("FAIL rsp got cyc=%0d rdata=%h err=%b hit=%b want cyc=%0d rdata=%h err=%b hit=%b",
                             cyc, bus.rsp_rdata, bus.rsp_err, bus.rsp_hit, e.cyc, e.rdata, e.err, e.hit);
                end
            end
        end
    end
    task automatic issue(input logic we, input logic [3:0] row, input logic [31:0] wd, input logic [3:0] wm,
                         input int lat, input logic [31:0] rd, input logic err, input logic hit, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout row=%0d got ready=%b want 1", row, bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_row   = row;
        bus.req_wdata = wd;
        bus.req_wmask = wm;
        @(posedge clk);
        #1;
        acc = cyc;
        sb.push_back('{cyc: cyc + lat, rdata: rd, err: err, hit: hit});
        bus.req_valid = 1'b0;
    endtask
    task automatic wr(input logic [3:0] row, input logic [31:0] wd, input logic [3:0] wm);
        int a;
        issue(1'b1, row, wd, wm, RC - 1, 32'h0, 1'b0, 1'b0, a);
    endtask
    task automatic rd_miss(input logic [3:0] row, input logic [31:0] d);
        int a;
        issue(1'b0, row, 32'h0, 4'h0, 1, d, 1'b0, 1'b0, a);
    endtask
    task automatic rd_hit(input logic [3:0] row, input logic [31:0] d);
        int a;
        issue(1'b0, row, 32'h0, 4'h0, 0, d, 1'b0, 1'b1, a);
    endtask
    initial begin
        int a, n;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_row   = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got ready=%b rsp_valid=%b rdata=%h want 1 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
        end
        wr(4'd0, 32'hDDCCBBAA, 4'hF);
        issue(1'b0, 4'd0, 32'h0, 4'h0, 1, 32'hDDCCBBAA, 1'b0, 1'b0, a);
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cyc != a + 1 + RC) begin
            failures++;
            $display("FAIL ready_return got cyc=%0d want %0d", cyc, a + 1 + RC);
        end
        rd_hit(4'd0, 32'hDDCCBBAA);
        rd_hit(4'd0, 32'hDDCCBBAA);
        rd_hit(4'd0, 32'hDDCCBBAA);
        rd_hit(4'd0, 32'hDDCCBBAA);
        wr(4'd2, 32'h11223344, 4'hF);
        rd_miss(4'd2, 32'h11223344);
        rd_miss(4'd0, 32'hDDCCBBAA);
        rd_miss(4'd2, 32'h11223344);
        wr(4'd2, 32'hFFFFFFFF, 4'b0101);
        rd_hit(4'd2, 32'h11FF33FF);
        rd_miss(4'd0, 32'hDDCCBBAA);
        rd_miss(4'd2, 32'h11FF33FF);
        issue(1'b0, 4'd15, 32'h0, 4'h0, 0, 32'h0, 1'b1, 1'b0, a);
        issue(1'b1, 4'd12, 32'h12345678, 4'hF, 0, 32'h0, 1'b1, 1'b0, a);
        rd_hit(4'd2, 32'h11FF33FF);
        wr(4'd2, 32'hA5A5A5A5, 4'h0);
        rd_hit(4'd2, 32'h11FF33FF);
        issue(1'b0, 4'd0, 32'h0, 4'h0, 1, 32'hDDCCBBAA, 1'b0, 1'b0, a);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_miss(4'd0, 32'h0);
        rd_hit(4'd0, 32'h0);
        rd_miss(4'd2, 32'h11FF33FF);
        repeat (RC + 6) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_rsp got pending=%0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
